dti_pr_iniu_pr_seq: RTL and testbench

Partial-reset sequencer for the DTI initiator NIU system-side slice. It accepts a 4-phase partial-reset request and freezes the req/rsp async FIFO halves (stall), then waits for the DTI protocol engine and both FIFOs to drain. It then drives clear and partial_reset for a fixed window, releases, and acknowledges. It sits beside the dti_pr / afifo_slv / afifo_mst instances and owns their stall, clear and partial_reset inputs.

---
 rtl/dti_pr_iniu_pr_seq.sv | 219 +++++++++++++++++++++
 tb/tb_dti_pr_iniu_pr_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dti_pr_iniu_pr_seq.sv
`default_nettype none
// ============================================================================
// Module   : dti_pr_iniu_pr_seq
// Brief    : Partial-reset sequencer for the DTI initiator NIU system slice.
//            Accepts a 4-phase pr_req/pr_ack handshake, stalls the req/rsp
//            async FIFO halves, waits for the protocol engine and both FIFOs
//            to drain (or for a drain timeout), pulses clear/partial_reset
//            for a fixed window, lets FIFO pointers settle for one cycle,
//            then acknowledges.
//
// Ports    : clk, rst_n          - system clock, async active-low reset
//            pr_req / pr_ack     - 4-phase partial-reset handshake
//            pr_busy             - sequencer is not idle
//            dti_idle,
//            req_full_zero,
//            rsp_idle            - drain status inputs (ANDed into "drained")
//            req_stall/rsp_stall - FIFO stall controls
//            req_clear/rsp_clear - FIFO clear controls
//            dti_partial_reset   - protocol engine partial reset
//            timeout_err         - sticky: last sequence hit the drain timeout
//
// Revision : 1.0 - initial release
// ============================================================================
module dti_pr_iniu_pr_seq #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int DRAIN_STABLE  = 2,
    parameter int CLEAR_CYCLES  = 4,
    parameter int CNT_W         = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pr_req,
    output logic pr_ack,
    output logic pr_busy,
    input  logic dti_idle,
    input  logic req_full_zero,
    input  logic rsp_idle,
    output logic req_stall,
    output logic rsp_stall,
    output logic req_clear,
    output logic rsp_clear,
    output logic dti_partial_reset,
    output logic timeout_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_drain   = 3'd1;
    localparam logic [2:0] c_st_clear   = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_stable   = CNT_W'(DRAIN_STABLE);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_clr_last = CNT_W'(CLEAR_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_stb_cnt;
    logic [CNT_W-1:0] r_clr_cnt;

    logic r_pr_ack;
    logic r_pr_busy;
    logic r_req_stall;
    logic r_rsp_stall;
    logic r_req_clear;
    logic r_rsp_clear;
    logic r_dti_partial_reset;
    logic r_timeout_err;

    // ------------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_tmo_cnt_nxt;
    logic [CNT_W-1:0] w_stb_cnt_nxt;
    logic [CNT_W-1:0] w_clr_cnt_nxt;
    logic             w_timeout_err_nxt;

    logic             w_drained;
    logic [CNT_W-1:0] w_tmo_inc;
    logic [CNT_W-1:0] w_stb_inc;
    logic [CNT_W-1:0] w_clr_inc;
    logic             w_stall_nxt;
    logic             w_clear_nxt;

    assign w_drained = dti_idle & req_full_zero & rsp_idle;

    // Saturating increments: the counters hold at all-ones rather than wrap.
    assign w_tmo_inc = (r_tmo_cnt == c_cnt_max) ? r_tmo_cnt : (r_tmo_cnt + c_cnt_one);
    assign w_stb_inc = (r_stb_cnt == c_cnt_max) ? r_stb_cnt : (r_stb_cnt + c_cnt_one);
    assign w_clr_inc = (r_clr_cnt == c_cnt_max) ? r_clr_cnt : (r_clr_cnt + c_cnt_one);

    always_comb begin
        w_state_nxt       = r_state;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_stb_cnt_nxt     = r_stb_cnt;
        w_clr_cnt_nxt     = r_clr_cnt;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            c_st_idle: begin
                if (pr_req) begin
                    w_state_nxt       = c_st_drain;
                    w_tmo_cnt_nxt     = '0;
                    w_stb_cnt_nxt     = '0;
                    w_timeout_err_nxt = 1'b0;
                end
            end

            c_st_drain: begin
                // The timeout count keeps running across drained glitches;
                // only the stability count restarts.
                w_tmo_cnt_nxt = w_tmo_inc;
                w_stb_cnt_nxt = w_drained ? w_stb_inc : '0;
                // Stable exit is checked first so it wins a same-cycle tie
                // with the timeout and leaves timeout_err clear.
                if (w_drained && (w_stb_inc >= c_stable)) begin
                    w_state_nxt   = c_st_clear;
                    w_clr_cnt_nxt = '0;
                end else if (r_tmo_cnt >= c_tmo_last) begin
                    w_state_nxt       = c_st_clear;
                    w_clr_cnt_nxt     = '0;
                    w_timeout_err_nxt = 1'b1;
                end
            end

            c_st_clear: begin
                if (r_clr_cnt >= c_clr_last) begin
                    w_state_nxt = c_st_release;
                end else begin
                    w_clr_cnt_nxt = w_clr_inc;
                end
            end

            // One settle cycle with stalls still up and clears already down.
            c_st_release: begin
                w_state_nxt = c_st_done;
            end

            c_st_done: begin
                if (!pr_req) begin
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so that each output
    // changes on the same edge as the state it belongs to.
    assign w_stall_nxt = (w_state_nxt == c_st_drain) ||
                         (w_state_nxt == c_st_clear) ||
                         (w_state_nxt == c_st_release);
    assign w_clear_nxt = (w_state_nxt == c_st_clear);

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_tmo_cnt <= '0;
            r_stb_cnt <= '0;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_stb_cnt <= w_stb_cnt_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers; async reset drops clear/partial_reset immediately.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pr_ack            <= 1'b0;
            r_pr_busy           <= 1'b0;
            r_req_stall         <= 1'b0;
            r_rsp_stall         <= 1'b0;
            r_req_clear         <= 1'b0;
            r_rsp_clear         <= 1'b0;
            r_dti_partial_reset <= 1'b0;
            r_timeout_err       <= 1'b0;
        end else begin
            r_pr_ack            <= (w_state_nxt == c_st_done);
            r_pr_busy           <= (w_state_nxt != c_st_idle);
            r_req_stall         <= w_stall_nxt;
            r_rsp_stall         <= w_stall_nxt;
            r_req_clear         <= w_clear_nxt;
            r_rsp_clear         <= w_clear_nxt;
            r_dti_partial_reset <= w_clear_nxt;
            r_timeout_err       <= w_timeout_err_nxt;
        end
    end

    assign pr_ack            = r_pr_ack;
    assign pr_busy           = r_pr_busy;
    assign req_stall         = r_req_stall;
    assign rsp_stall         = r_rsp_stall;
    assign req_clear         = r_req_clear;
    assign rsp_clear         = r_rsp_clear;
    assign dti_partial_reset = r_dti_partial_reset;
    assign timeout_err       = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_dti_pr_iniu_pr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dti_pr_iniu_pr_seq
// Brief    : Self-checking bench for dti_pr_iniu_pr_seq. Two instances share
//            the drain inputs: one with default parameters, one with a short
//            drain timeout. Expected outputs come from a timeline model that
//            walks the stimulus arrays and places each sequence phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dti_pr_iniu_pr_seq;

    localparam int MAXN   = 400;
    localparam int DS     = 2;
    localparam int CC     = 4;
    localparam int DT_A   = 1024;
    localparam int DT_T   = 16;

    // Expected-vector bit order: {ack, busy, req_stall, rsp_stall,
    //                             req_clear, rsp_clear, partial_reset, err}
    localparam logic [7:0] c_v_stall = 8'b0111_0000;
    localparam logic [7:0] c_v_clear = 8'b0111_1110;
    localparam logic [7:0] c_v_done  = 8'b1100_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pr_req_a = 1'b0;
    logic pr_req_t = 1'b0;
    logic dti_idle = 1'b1;
    logic req_full_zero = 1'b1;
    logic rsp_idle = 1'b1;

    logic ack_a, busy_a, rqs_a, rss_a, rqc_a, rsc_a, prs_a, err_a;
    logic ack_t, busy_t, rqs_t, rss_t, rqc_t, rsc_t, prs_t, err_t;

    wire [7:0] obs_a = {ack_a, busy_a, rqs_a, rss_a, rqc_a, rsc_a, prs_a, err_a};
    wire [7:0] obs_t = {ack_t, busy_t, rqs_t, rss_t, rqc_t, rsc_t, prs_t, err_t};

    bit         req_a [MAXN];
    bit         req_t [MAXN];
    bit         drn   [MAXN];
    logic [7:0] ex_a  [MAXN];
    logic [7:0] ex_t  [MAXN];
    bit         te_a = 1'b0;
    bit         te_t = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dti_pr_iniu_pr_seq dut (
        .clk(clk), .rst_n(rst_n), .pr_req(pr_req_a), .pr_ack(ack_a),
        .pr_busy(busy_a), .dti_idle(dti_idle), .req_full_zero(req_full_zero),
        .rsp_idle(rsp_idle), .req_stall(rqs_a), .rsp_stall(rss_a),
        .req_clear(rqc_a), .rsp_clear(rsc_a), .dti_partial_reset(prs_a),
        .timeout_err(err_a)
    );

    dti_pr_iniu_pr_seq #(.DRAIN_TIMEOUT(DT_T)) dut_t (
        .clk(clk), .rst_n(rst_n), .pr_req(pr_req_t), .pr_ack(ack_t),
        .pr_busy(busy_t), .dti_idle(dti_idle), .req_full_zero(req_full_zero),
        .rsp_idle(rsp_idle), .req_stall(rqs_t), .rsp_stall(rss_t),
        .req_clear(rqc_t), .rsp_clear(rsc_t), .dti_partial_reset(prs_t),
        .timeout_err(err_t)
    );

    // ------------------------------------------------------------------------
    // Reference model: walks request/drain arrays and lays out the phases of
    // each sequence on the cycle axis. Output at cycle k reflects the inputs
    // of cycles before k.
    // ------------------------------------------------------------------------
    task automatic model(input int n, input int dt, input bit sel,
                         input bit te0, output bit te_end);
        logic [7:0] e [MAXN];
        bit r [MAXN];
        int k, j, run, last;
        bit te, forced;
        for (int i = 0; i < MAXN; i++) begin
            r[i] = sel ? req_t[i] : req_a[i];
            e[i] = 8'h00;
        end
        te = te0;
        k = 0;
        while (k < n) begin
            e[k] = {7'b0, te};
            if (r[k]) begin
                te = 1'b0;
                run = 0;
                forced = 1'b0;
                last = -1;
                for (int d = k + 1; d < n; d++) begin
                    e[d] = c_v_stall;
                    run = drn[d] ? run + 1 : 0;
                    if (run >= DS) begin
                        last = d;
                        break;
                    end
                    if (d - k >= dt) begin
                        last = d;
                        forced = 1'b1;
                        break;
                    end
                end
                if (last < 0) begin
                    k = n;
                end else begin
                    te = forced;
                    for (int c = last + 1; c <= last + CC && c < n; c++)
                        e[c] = c_v_clear | {7'b0, te};
                    if (last + CC + 1 < n) e[last + CC + 1] = c_v_stall | {7'b0, te};
                    j = last + CC + 2;
                    while (j < n) begin
                        e[j] = c_v_done | {7'b0, te};
                        if (!r[j]) break;
                        j++;
                    end
                    k = j + 1;
                end
            end else begin
                k++;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (sel) ex_t[i] = e[i];
            else     ex_a[i] = e[i];
        end
        te_end = te;
    endtask

    task automatic drive_cycle(input int k);
        pr_req_a = req_a[k];
        pr_req_t = req_t[k];
        if (drn[k]) {dti_idle, req_full_zero, rsp_idle} = 3'b111;
        else        {dti_idle, req_full_zero, rsp_idle} = 3'($urandom_range(0, 6));
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            req_a[i] = 1'b0;
            req_t[i] = 1'b0;
            drn[i]   = 1'b1;
        end
    endtask

    task automatic prep_ideal();
        clear_stim();
        for (int i = 0; i < 12; i++) req_a[i] = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        pr_req_a = 1'b0;
        pr_req_t = 1'b0;
        {dti_idle, req_full_zero, rsp_idle} = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if ({obs_a, obs_t} !== 16'h0000) begin
            $display("FAIL reset_hold got=%b/%b exp=0/0", obs_a, obs_t);
        end else passes++;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({obs_a, obs_t} !== 16'h0000) begin
                $display("FAIL reset_idle cyc=%0d got=%b/%b exp=0/0", k, obs_a, obs_t);
            end else passes++;
        end
        te_a = 1'b0;
        te_t = 1'b0;
    endtask

    task automatic test_ideal();
        prep_ideal();
        model(30, DT_A, 1'b0, te_a, te_a);
        model(30, DT_T, 1'b1, te_t, te_t);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL ideal_a cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            checks++;
            if (obs_t !== ex_t[k]) $display("FAIL ideal_t cyc=%0d got=%b exp=%b", k, obs_t, ex_t[k]);
            else passes++;
            if (k == 8) begin
                checks++;
                if (ack_a !== 1'b1) $display("FAIL ideal_ack_rise got=%b exp=1", ack_a);
                else passes++;
            end
            if (k == 13) begin
                checks++;
                if (ack_a !== 1'b0) $display("FAIL ideal_ack_fall got=%b exp=0", ack_a);
                else passes++;
            end
            drive_cycle(k);
        end
    endtask

    task automatic test_slow_drain();
        clear_stim();
        for (int i = 0; i < 71; i++) req_a[i] = 1'b1;
        for (int i = 0; i < 51; i++) drn[i] = 1'b0;
        model(100, DT_A, 1'b0, te_a, te_a);
        model(100, DT_T, 1'b1, te_t, te_t);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL slow_a cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            if (k == 53) begin
                checks++;
                if (rqc_a !== 1'b1 || err_a !== 1'b0)
                    $display("FAIL slow_clear_start got=%b%b exp=10", rqc_a, err_a);
                else passes++;
            end
            drive_cycle(k);
        end
    endtask

    task automatic test_glitch();
        clear_stim();
        for (int i = 0; i < 16; i++) req_a[i] = 1'b1;
        drn[1] = 1'b1; drn[2] = 1'b0; drn[3] = 1'b1; drn[4] = 1'b1;
        model(30, DT_A, 1'b0, te_a, te_a);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL glitch_a cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            if (k == 4 || k == 5) begin
                checks++;
                if (rqc_a !== (k == 5)) $display("FAIL glitch_clear cyc=%0d got=%b exp=%b", k, rqc_a, (k == 5));
                else passes++;
            end
            drive_cycle(k);
        end
    endtask

    task automatic test_timeout();
        clear_stim();
        for (int i = 0; i < 30; i++) begin
            req_t[i] = 1'b1;
            drn[i]   = 1'b0;
        end
        for (int i = 40; i < 46; i++) req_t[i] = 1'b1;
        model(80, DT_A, 1'b0, te_a, te_a);
        model(80, DT_T, 1'b1, te_t, te_t);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            checks++;
            if (obs_t !== ex_t[k]) $display("FAIL timeout_t cyc=%0d got=%b exp=%b", k, obs_t, ex_t[k]);
            else passes++;
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL timeout_a cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            if (k == 16 || k == 17) begin
                checks++;
                if ({rqc_t, err_t} !== {2{k == 17}})
                    $display("FAIL timeout_force cyc=%0d got=%b%b exp=%b%b", k, rqc_t, err_t, k == 17, k == 17);
                else passes++;
            end
            if (k == 41) begin
                checks++;
                if (err_t !== 1'b0) $display("FAIL timeout_err_clear got=%b exp=0", err_t);
                else passes++;
            end
            drive_cycle(k);
        end
    endtask

    task automatic test_back_to_back();
        bit ra, rt;
        clear_stim();
        ra = 1'b0;
        rt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i < 260) begin
                if ($urandom_range(0, 9) == 0) ra = ~ra;
                if ($urandom_range(0, 9) == 0) rt = ~rt;
                req_a[i] = ra;
                req_t[i] = rt;
                drn[i] = ($urandom_range(0, 3) != 0);
            end
        end
        model(300, DT_A, 1'b0, te_a, te_a);
        model(300, DT_T, 1'b1, te_t, te_t);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL random_a cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            checks++;
            if (obs_t !== ex_t[k]) $display("FAIL random_t cyc=%0d got=%b exp=%b", k, obs_t, ex_t[k]);
            else passes++;
            drive_cycle(k);
        end
    endtask

    task automatic test_async_reset();
        prep_ideal();
        model(30, DT_A, 1'b0, te_a, te_a);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL arst_pre cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            if (k < 4) drive_cycle(k);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_a, obs_t} !== 16'h0000) $display("FAIL arst_drop got=%b/%b exp=0/0", obs_a, obs_t);
        else passes++;
        pr_req_a = 1'b0;
        pr_req_t = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        te_a = 1'b0;
        te_t = 1'b0;
        model(30, DT_A, 1'b0, te_a, te_a);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ex_a[k]) $display("FAIL arst_rerun cyc=%0d got=%b exp=%b", k, obs_a, ex_a[k]);
            else passes++;
            drive_cycle(k);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_slow_drain();
        test_glitch();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
